// File: rtl/inst_axi_rd_bridge_if.sv
// Fetch-side SRAM-like instruction port plus AXI4 AR/R channels for inst_axi_rd_bridge.
// master: the bridge's view; slave: the fetch stage and AXI slave side.
interface inst_axi_rd_bridge_if;
  // fetch-side SRAM-like port
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Fetch SRAM-like instruction port to read-only AXI4 master, with outstanding-read tracking.
// Optional macro INST_BRIDGE_RBUF_EN registers the read-data return path.
module inst_axi_rd_bridge #(
  parameter logic [3:0]  AXI_ID          = 4'd0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_axi_rd_bridge_if.master  bus_io
);

  localparam int unsigned    CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {StArIdle, StArSend} ar_state_e;

  ar_state_e       state_q;
  logic            arvalid_q;
  logic [31:0]     araddr_q;
  logic [2:0]      arsize_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic rready;
  logic ar_hs;
  logic r_hs;
  logic dec;
  logic unused_sig;

  assign rready = ~reset;
  assign ar_hs  = arvalid_q & bus_io.arready;
  assign r_hs   = bus_io.rvalid & rready & bus_io.rlast;

  // AR channel FSM with registered arvalid/araddr/arsize
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StArIdle;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'h0;
      arsize_q  <= 3'b000;
    end else begin
      unique case (state_q)
        StArIdle: begin
          if (bus_io.inst_sram_req && !bus_io.inst_sram_wr && (cnt_q < MaxCnt)) begin
            state_q   <= StArSend;
            arvalid_q <= 1'b1;
            araddr_q  <= bus_io.inst_sram_addr;
            arsize_q  <= {1'b0, bus_io.inst_sram_size};
          end
        end
        StArSend: begin
          if (bus_io.arready) begin
            state_q   <= StArIdle;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StArIdle;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_BRIDGE_RBUF_EN
  logic        data_ok_q;
  logic [31:0] rdata_q;

  // Single-entry return slot; drains every cycle so rready can stay high.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= r_hs;
      if (r_hs) begin
        // An error response is handed to fetch as a nop word.
        rdata_q <= (bus_io.rresp != 2'b00) ? 32'h0 : bus_io.rdata;
      end
    end
  end

  assign dec                      = data_ok_q;
  assign bus_io.inst_sram_data_ok = data_ok_q;
  assign bus_io.inst_sram_rdata   = rdata_q;
  assign unused_sig = ^{bus_io.inst_sram_wstrb, bus_io.inst_sram_wdata, bus_io.rid};
`else
  assign dec                      = r_hs;
  assign bus_io.inst_sram_data_ok = r_hs;
  assign bus_io.inst_sram_rdata   = bus_io.rdata;
  assign unused_sig = ^{bus_io.inst_sram_wstrb, bus_io.inst_sram_wdata, bus_io.rid,
                        bus_io.rresp};
`endif

  // Outstanding count; a return with nothing outstanding saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!ar_hs && dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_io.inst_sram_addr_ok = ar_hs;

  assign bus_io.arid    = AXI_ID;
  assign bus_io.araddr  = araddr_q;
  assign bus_io.arlen   = 8'd0;
  assign bus_io.arsize  = arsize_q;
  assign bus_io.arburst = 2'b01;
  assign bus_io.arlock  = 2'b00;
  assign bus_io.arcache = 4'b0000;
  assign bus_io.arprot  = 3'b000;
  assign bus_io.arvalid = arvalid_q;
  assign bus_io.rready  = rready;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed self-checking bench for inst_axi_rd_bridge (either build of INST_BRIDGE_RBUF_EN).
module tb_inst_axi_rd_bridge;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  inst_axi_rd_bridge_if bus ();

  inst_axi_rd_bridge #(
    .AXI_ID          (4'd0),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One R beat with rlast; returns with the count update already applied.
  task automatic r_beat(input string tag, input logic [31:0] d);
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rdata  = d;
`ifdef INST_BRIDGE_RBUF_EN
    tick();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    settle();
    chk({tag, "_data_ok"}, bus.inst_sram_data_ok, 1);
    chk({tag, "_rdata"}, bus.inst_sram_rdata, d);
    tick();
`else
    settle();
    chk({tag, "_data_ok"}, bus.inst_sram_data_ok, 1);
    chk({tag, "_rdata"}, bus.inst_sram_rdata, d);
    tick();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
`endif
    settle();
    chk({tag, "_data_ok_drop"}, bus.inst_sram_data_ok, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'd2;
    bus.inst_sram_wstrb = 4'h0;
    bus.inst_sram_addr  = 32'h0;
    bus.inst_sram_wdata = 32'h0;
    bus.arready         = 1'b0;
    bus.rid             = 4'h0;
    bus.rdata           = 32'h0;
    bus.rresp           = 2'b00;
    bus.rlast           = 1'b0;
    bus.rvalid          = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_rready_low", bus.rready, 0);
    reset = 1'b0;
    settle();
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_araddr", bus.araddr, 32'h0);
    chk("rst_arsize", bus.arsize, 3'b000);
    chk("rst_addr_ok", bus.inst_sram_addr_ok, 0);
    chk("rst_data_ok", bus.inst_sram_data_ok, 0);
    chk("rst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("rst_rready", bus.rready, 1);
    chk("rst_cnt", dut.cnt_q, 0);
    chk("const_arlen", bus.arlen, 8'd0);
    chk("const_arburst", bus.arburst, 2'b01);
    chk("const_arid", bus.arid, 4'd0);

    // Basic fetch: addr_ok two cycles after req
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc0_0000;
    bus.arready        = 1'b1;
    settle();
    chk("t2_idle_arvalid", bus.arvalid, 0);
    chk("t2_idle_addr_ok", bus.inst_sram_addr_ok, 0);
    tick();
    chk("t2_arvalid", bus.arvalid, 1);
    chk("t2_araddr", bus.araddr, 32'hbfc0_0000);
    chk("t2_arsize", bus.arsize, 3'b010);
    chk("t2_addr_ok", bus.inst_sram_addr_ok, 1);
    tick();
    bus.inst_sram_req = 1'b0;
    settle();
    chk("t2_arvalid_drop", bus.arvalid, 0);
    chk("t2_cnt1", dut.cnt_q, 1);
    r_beat("t2_r", 32'h3c1d_0000);
    chk("t2_cnt0", dut.cnt_q, 0);

    // Slave stalls AR for 5 cycles
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc0_0010;
    bus.arready        = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_arvalid", bus.arvalid, 1);
      chk("t3_hold_araddr", bus.araddr, 32'hbfc0_0010);
      chk("t3_hold_addr_ok", bus.inst_sram_addr_ok, 0);
      tick();
    end
    bus.arready = 1'b1;
    settle();
    chk("t3_addr_ok", bus.inst_sram_addr_ok, 1);
    tick();
    bus.inst_sram_req = 1'b0;
    settle();
    chk("t3_arvalid_drop", bus.arvalid, 0);
    chk("t3_addr_ok_drop", bus.inst_sram_addr_ok, 0);
    chk("t3_cnt1", dut.cnt_q, 1);
    r_beat("t3_r", 32'h1234_5678);
    chk("t3_cnt0", dut.cnt_q, 0);

    // Fill to MAX_OUTSTANDING, third request blocked until a return
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc0_0000;
    tick();
    chk("t4_a_addr_ok", bus.inst_sram_addr_ok, 1);
    tick();
    bus.inst_sram_addr = 32'hbfc0_0004;
    settle();
    chk("t4_gap_arvalid", bus.arvalid, 0);
    tick();
    chk("t4_b_addr_ok", bus.inst_sram_addr_ok, 1);
    chk("t4_b_araddr", bus.araddr, 32'hbfc0_0004);
    tick();
    bus.inst_sram_addr = 32'hbfc0_0008;
    settle();
    chk("t4_cnt2", dut.cnt_q, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_full_arvalid", bus.arvalid, 0);
      chk("t4_full_addr_ok", bus.inst_sram_addr_ok, 0);
    end
    r_beat("t4_r", 32'haaaa_0001);
    chk("t4_cnt_after_r", dut.cnt_q, 1);
    chk("t4_c_not_yet", bus.arvalid, 0);
    tick();
    chk("t4_c_arvalid", bus.arvalid, 1);
    chk("t4_c_araddr", bus.araddr, 32'hbfc0_0008);
    chk("t4_c_addr_ok", bus.inst_sram_addr_ok, 1);
    tick();
    bus.inst_sram_req = 1'b0;
    settle();
    chk("t4_cnt2_again", dut.cnt_q, 2);
    r_beat("t4_r2", 32'haaaa_0002);
    chk("t4_cnt1_again", dut.cnt_q, 1);

    // AR handshake coincides with a return at cnt=1
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc0_000c;
`ifdef INST_BRIDGE_RBUF_EN
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rdata  = 32'h5555_aaaa;
    tick();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    settle();
`else
    tick();
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rdata  = 32'h5555_aaaa;
    settle();
`endif
    chk("t5_addr_ok", bus.inst_sram_addr_ok, 1);
    chk("t5_data_ok", bus.inst_sram_data_ok, 1);
    chk("t5_rdata", bus.inst_sram_rdata, 32'h5555_aaaa);
    tick();
    bus.inst_sram_req = 1'b0;
    bus.rvalid        = 1'b0;
    bus.rlast         = 1'b0;
    settle();
    chk("t5_cnt_stays1", dut.cnt_q, 1);
    r_beat("t5_r", 32'h0bad_f00d);
    chk("t5_cnt0", dut.cnt_q, 0);

    // Stray return with nothing outstanding: passed through, count saturates
    r_beat("sat_r", 32'h7777_0000);
    chk("sat_cnt0", dut.cnt_q, 0);

    // Non-last beat is consumed silently
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b0;
    bus.rdata  = 32'h1111_2222;
    tick();
    bus.rvalid = 1'b0;
    settle();
    chk("nolast_data_ok", bus.inst_sram_data_ok, 0);
    chk("nolast_cnt", dut.cnt_q, 0);

    // Write requests are never accepted
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_wr   = 1'b1;
    bus.inst_sram_addr = 32'hbfc0_0020;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wr_arvalid", bus.arvalid, 0);
      chk("wr_addr_ok", bus.inst_sram_addr_ok, 0);
    end
    bus.inst_sram_req = 1'b0;
    bus.inst_sram_wr  = 1'b0;
    settle();
    chk("end_cnt", dut.cnt_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Converts the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) into a read-only AXI4 master (AR and R channels only).
- Sits directly downstream of the fetch stage's instruction-request outputs and upstream of the system AXI interconnect.
- Tracks outstanding reads so the fetch stage sees in-order data_ok pulses, one per accepted address.

Parameters:
- AXI_ID, 4'd0: constant driven on arid; rid is not checked.
- MAX_OUTSTANDING, 2: maximum accepted-but-unreturned reads (1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_sram_req  in  1  fetch request; held high by the master until addr_ok
- inst_sram_wr  in  1  write flag; must be 0
- inst_sram_size  in  2  log2 byte count; passed to arsize
- inst_sram_wstrb  in  4  unused
- inst_sram_addr  in  32  fetch address
- inst_sram_wdata  in  32  unused
- inst_sram_addr_ok  out  1  address accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- arid  out  4  = AXI_ID
- araddr  out  32  latched request address
- arlen  out  8  = 0 (single beat)
- arsize  out  3  = {1'b0, latched size}
- arburst  out  2  = 2'b01
- arlock  out  2  = 0
- arcache  out  4  = 0
- arprot  out  3  = 0
- arvalid  out  1  address valid
- arready  in  1  slave accepts address
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  ignored, except under the optional feature below
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  always 1 after reset

Behaviour:
- Reset: state AR_IDLE, arvalid=0, araddr=0, arsize=0, outstanding count cnt=0, addr_ok=0, data_ok=0, rdata out=0.
- rready is 0 during reset and 1 otherwise.
- cnt width is $clog2(MAX_OUTSTANDING+1).
- AR FSM, AR_IDLE -> AR_SEND:
  - Transition when inst_sram_req && !inst_sram_wr && cnt<MAX_OUTSTANDING.
  - At the transition, latch addr and size; arvalid=1 from the next cycle.
- AR FSM, AR_SEND:
  - Hold arvalid, araddr and arsize stable until arready.
  - On arvalid&&arready: inst_sram_addr_ok=1 in that same cycle (combinational), arvalid drops next cycle, go to AR_IDLE.
- addr_ok is asserted only on the AR handshake, so there is exactly one addr_ok per AR transfer. The master holds req/addr, so the latched address matches the live address.
- Minimum request-to-addr_ok latency is 2 cycles (req seen in AR_IDLE, then AR_SEND with arready=1). The next request can be taken in the cycle after addr_ok.
- Write requests (wr=1) are never accepted: the FSM stays in AR_IDLE and addr_ok=0.
- Full: when cnt==MAX_OUTSTANDING, AR_IDLE does not leave even with req high.
- Data return:
  - data_ok = rvalid && rready && rlast, combinational; inst_sram_rdata = rdata.
  - Beats with rlast=0 are consumed silently (defensive; arlen=0 means the slave should never send them).
- cnt update:
  - +1 on an AR handshake, -1 on a data_ok beat.
  - Both in the same cycle: cnt unchanged.
  - data_ok with cnt==0 is a protocol error: cnt saturates at 0, and data_ok is still passed through.
- Ordering: a single ID is used, so responses return in issue order. The bridge does not reorder.
- Cancelled fetches are the fetch stage's concern: every accepted address produces exactly one data_ok.

Optional Feature:
- Macro INST_BRIDGE_RBUF_EN.
- Defined:
  - rdata and the data_ok condition are registered; data_ok and inst_sram_rdata appear 1 cycle after the R handshake.
  - cnt decrements on the registered pulse.
  - rready = 1, because the registered slot is single-entry and always drains next cycle.
  - rresp!=0 forces the registered rdata to 32'h0 (treated as a nop).
- Undefined: combinational path as described in Behaviour; rresp fully ignored.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 except rready=1; cnt=0.
- req=1, addr=32'hbfc00000, arready=1 → arvalid in cycle 2 with araddr=bfc00000, arsize=3'b010, addr_ok=1 the same cycle. Then rvalid=1, rlast=1, rdata=32'h3c1d0000 → data_ok=1 with rdata=3c1d0000 (one cycle later when INST_BRIDGE_RBUF_EN is defined).
- arready held 0 for 5 cycles → arvalid and araddr stable, addr_ok=0 throughout. arready=1 → single addr_ok, arvalid falls next cycle.
- Two requests (bfc00000, bfc00004) with rvalid held 0 → both accepted, cnt=2. A third request (bfc00008) → no arvalid. One R beat → cnt=1, third AR issues.
- AR handshake and R beat in the same cycle at cnt=1 → cnt stays 1.
- req=1 with wr=1 → no arvalid and no addr_ok for 10 cycles.
